// File: rtl/stat_spill_readout_ctrl_pkg.sv
// Shared types and constants for the spill-level stat readout controller.
package stat_spill_readout_ctrl_pkg;

  localparam int          STAT_W       = 32;
  localparam logic [7:0]  HDR_TAG_DEF  = 8'hA5;

  // Header word layout: {tag[31:24], 4'h0, ncnt[19:16], spill id[15:0]}
  localparam int HDR_TAG_LSB  = 24;
  localparam int HDR_NCNT_LSB = 16;
  localparam int HDR_ID_LSB   = 0;

  typedef enum logic [2:0] {IDLE, LIVE, SNAP, HDR, DATA} state_t;

  function automatic logic [STAT_W-1:0] make_hdr(input logic [7:0]  tag,
                                                 input logic [3:0]  ncnt,
                                                 input logic [15:0] id);
    logic [STAT_W-1:0] w;
    w                     = '0;
    w[HDR_TAG_LSB  +: 8]  = tag;
    w[HDR_NCNT_LSB +: 4]  = ncnt;
    w[HDR_ID_LSB   +: 16] = id;
    return w;
  endfunction

endpackage

// File: rtl/stat_spill_readout_ctrl_if.sv
// Valid/ready readout stream carrying header + counter words of a spill record.
interface stat_spill_readout_ctrl_if;
  import stat_spill_readout_ctrl_pkg::*;

  logic [STAT_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input  ready);
  modport slave  (input  data, input  valid, input  last, output ready);
endinterface

// File: rtl/stat_spill_readout_ctrl_live_edge_det.sv
// Registered edge detector for the spill live window. pre_live resets to 1 so
// a window already open at reset release is not taken as a spill start.
module live_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in_live,
  output logic rise,
  output logic fall
);
  logic pre_live;

  // Previous-cycle copy of the live level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_live <= 1'b1;
    else        pre_live <= in_live;
  end

  assign rise = in_live & ~pre_live;
  assign fall = ~in_live & pre_live;
endmodule

// File: rtl/stat_spill_readout_ctrl.sv
// Spill controller: waits for a live window to close, snapshots all counters,
// then streams header + NCNT counter words. A window that opens and closes
// while a record is still going out is dropped and flagged as overrun.
module stat_spill_readout_ctrl
  import stat_spill_readout_ctrl_pkg::*;
#(
  parameter int         NCNT    = 4,
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_live,
  input  logic [NCNT*STAT_W-1:0]   cnt_in,
  stat_spill_readout_ctrl_if.master out,
  output logic [15:0]              spill_id,
  output logic                     busy,
  output logic                     overrun
);
  localparam int               IDX_W    = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCNT - 1);

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q;
  logic [NCNT-1:0][STAT_W-1:0]    lane_in;
  logic [NCNT-1:0][STAT_W-1:0]    snap_q;
  logic [15:0]                    spill_q;
  logic                           pend_q, pend_d;
  logic                           ovr_q;
  logic                           rise, fall;
  logic                           accept, rec_busy, rec_done, drop, resume_live;

  live_edge_det u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_live (in_live),
    .rise    (rise),
    .fall    (fall)
  );

  // Unpack the flat counter bus into per-counter lanes
  for (genvar k = 0; k < NCNT; k++) begin : g_lane
    assign lane_in[k] = cnt_in[k*STAT_W +: STAT_W];
  end

  assign accept   = out.valid & out.ready;
  assign rec_busy = (state_q == SNAP) || (state_q == HDR) || (state_q == DATA);
  assign rec_done = (state_q == DATA) && accept && (idx_q == IDX_LAST);
  // While busy, pre_live can only be high after a rise seen during the record,
  // so a fall here always closes a window that has no snapshot of its own.
  assign drop     = rec_busy && fall && pend_q;
  // A window opened during the record and still open when the record ends
  assign resume_live = (pend_q & ~fall) | rise;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and pending-live tracking
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (rec_busy && rise) pend_d = 1'b1;
    if (drop)             pend_d = 1'b0;
    case (state_q)
      IDLE: if (rise)   state_d = LIVE;
      LIVE: if (fall)   state_d = SNAP;
      SNAP:             state_d = HDR;
      HDR:  if (accept) state_d = DATA;
      DATA: if (rec_done) begin
        state_d = resume_live ? LIVE : IDLE;
        pend_d  = 1'b0;
      end
      default:          state_d = IDLE;
    endcase
  end

  // Stream outputs decoded from state; data held stable by the registers behind it
  always_comb begin
    out.valid = 1'b0;
    out.last  = 1'b0;
    out.data  = '0;
    case (state_q)
      HDR: begin
        out.valid = 1'b1;
        out.data  = make_hdr(HDR_TAG, 4'(NCNT), spill_q + 16'd1);
      end
      DATA: begin
        out.valid = 1'b1;
        out.data  = snap_q[idx_q];
        out.last  = (idx_q == IDX_LAST);
      end
      default: ;
    endcase
  end

  // Word index within the counter section
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   idx_q <= '0;
    else if (state_q == HDR && accept)            idx_q <= '0;
    else if (state_q == DATA && accept && !rec_done) idx_q <= idx_q + 1'b1;
  end

  // Snapshot bank, loaded once in SNAP and held for the whole record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 snap_q <= '0;
    else if (state_q == SNAP)   snap_q <= lane_in;
  end

  // Completed record id, pending live flag and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spill_q <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (rec_done) spill_q <= spill_q + 16'd1;
      if (drop)     ovr_q   <= 1'b1;
    end
  end

  assign spill_id = spill_q;
  assign busy     = rec_busy;
  assign overrun  = ovr_q;
endmodule

// File: tb/tb_stat_spill_readout_ctrl.sv
// Directed bench with a word scoreboard for stat_spill_readout_ctrl.
module tb_stat_spill_readout_ctrl;
  localparam int NCNT = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic               clk;
  logic               rst_n;
  logic               in_live;
  logic [NCNT*32-1:0] cnt_in;
  logic [15:0]        spill_id;
  logic               busy;
  logic               overrun;

  stat_spill_readout_ctrl_if bus ();

  stat_spill_readout_ctrl #(.NCNT(NCNT), .HDR_TAG(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_live  (in_live),
    .cnt_in   (cnt_in),
    .out      (bus),
    .spill_id (spill_id),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  word_t       sb[$];
  logic [15:0] exp_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected record: header with next id, then the counter words
  task automatic push_record(input logic [NCNT*32-1:0] cv);
    word_t w;
    exp_id = exp_id + 16'd1;
    w.data = {8'hA5, 4'h0, 4'(NCNT), exp_id};
    w.last = 1'b0;
    sb.push_back(w);
    for (int k = 0; k < NCNT; k++) begin
      w.data = cv[k*32 +: 32];
      w.last = (k == NCNT - 1);
      sb.push_back(w);
    end
  endtask

  // One-cycle live pulse; returns in the SNAP cycle
  task automatic spill(input logic [NCNT*32-1:0] cv);
    cnt_in  = cv;
    in_live = 1'b1;
    step();
    in_live = 1'b0;
    push_record(cv);
    step();
  endtask

  // mode 0: ready held high, mode 1: ready toggles 1,0,1,0..
  task automatic drain(input int mode);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.valid) && n < 60) begin
      bus.ready = (mode == 0) ? 1'b1 : ((n % 2) == 0);
      step();
      n++;
    end
    check("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  // Scoreboard monitor and stall-stability checker, sampled on the falling edge
  logic        stall_q = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("valid_hold", 32'(bus.valid), 32'd1);
        check("data_hold", bus.data, hold_data);
        check("last_hold", 32'(bus.last), 32'(hold_last));
      end
      if (bus.valid && bus.ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          word_t w;
          w = sb.pop_front();
          check("word_data", bus.data, w.data);
          check("word_last", 32'(bus.last), 32'(w.last));
        end
      end
      stall_q   = bus.valid & ~bus.ready;
      hold_data = bus.data;
      hold_last = bus.last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_id    = 16'd0;
    rst_n     = 1'b0;
    in_live   = 1'b1;
    cnt_in    = '0;
    bus.ready = 1'b0;
    #1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_last", 32'(bus.last), 32'd0);
    check("rst_data", bus.data, 32'd0);
    check("rst_spill_id", 32'(spill_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: live already high at reset release, then falls -> no record
    step();
    in_live = 1'b0;
    repeat (4) step();
    check("t1_spill_id", 32'(spill_id), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_valid", 32'(bus.valid), 32'd0);

    // 2: full-rate readout, header two cycles after the fall
    bus.ready = 1'b1;
    spill({32'd4, 32'd3, 32'd2, 32'd1});
    check("t2_snap_busy", 32'(busy), 32'd1);
    check("t2_snap_valid", 32'(bus.valid), 32'd0);
    step();
    check("t2_hdr_at_fall_plus2", 32'(bus.valid), 32'd1);
    for (int i = 0; i < NCNT; i++) begin
      step();
      check("t2_b2b_valid", 32'(bus.valid), 32'd1);
    end
    step();
    check("t2_end_valid", 32'(bus.valid), 32'd0);
    check("t2_spill_id", 32'(spill_id), 32'(exp_id));
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: ready toggling, same words, held while stalled
    spill({32'd4, 32'd3, 32'd2, 32'd1});
    drain(1);
    check("t3_spill_id", 32'(spill_id), 32'(exp_id));

    // 4: counters change while the header is stalled
    bus.ready = 1'b0;
    spill({32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001});
    step();
    cnt_in = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    repeat (2) step();
    drain(0);
    check("t4_spill_id", 32'(spill_id), 32'(exp_id));

    // 5: second window opens and closes during a stalled header -> dropped
    bus.ready = 1'b0;
    spill({32'h0A, 32'h0B, 32'h0C, 32'h0D});
    step();
    in_live = 1'b1;
    step();
    check("t5_overrun_pre", 32'(overrun), 32'd0);
    in_live = 1'b0;
    step();
    check("t5_overrun_set", 32'(overrun), 32'd1);
    step();
    drain(0);
    check("t5_spill_id", 32'(spill_id), 32'(exp_id));
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_overrun_sticky", 32'(overrun), 32'd1);
    spill({32'h1A, 32'h1B, 32'h1C, 32'h1D});
    drain(0);
    check("t5_third_spill_id", 32'(spill_id), 32'(exp_id));

    // 6: reset in the middle of the counter words
    bus.ready = 1'b0;
    spill({32'h21, 32'h22, 32'h23, 32'h24});
    step();
    bus.ready = 1'b1;
    repeat (2) step();
    bus.ready = 1'b0;
    check("t6_mid_data_valid", 32'(bus.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.valid), 32'd0);
    check("t6_spill_id", 32'(spill_id), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    sb.delete();
    exp_id = 16'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    bus.ready = 1'b1;
    spill({32'h31, 32'h32, 32'h33, 32'h34});
    drain(0);
    check("t6_next_spill_id", 32'(spill_id), 32'd1);

    // 7: id wrap from FFFF
    force dut.spill_q = 16'hFFFF;
    step();
    release dut.spill_q;
    step();
    exp_id = 16'hFFFF;
    check("t7_preset_id", 32'(spill_id), 32'h0000FFFF);
    spill({32'h41, 32'h42, 32'h43, 32'h44});
    drain(0);
    check("t7_wrap_id", 32'(spill_id), 32'd0);
    check("t7_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
